// File: rtl/pilha_rpn_param.sv
// RPN operand stack with an integrated three-step evaluation unit (accept, compute, write back).
// Element 0 is the top; pushes and pops shift the whole array by one position.
module pilha_rpn_param #(
   parameter int LARGURA      = 8,
   parameter int PROFUNDIDADE = 8,
   parameter int LARG_CONT    = $clog2(PROFUNDIDADE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LARGURA-1:0]   entrada,
   input  logic                 entrada_numero,
   input  logic                 executar,
   input  logic [2:0]           operacao,
   input  logic                 limpar_erro,
   output logic                 pronto,
   output logic [LARGURA-1:0]   topo,
   output logic [LARGURA-1:0]   segundo,
   output logic [LARG_CONT-1:0] contagem,
   output logic                 pilha_vazia,
   output logic                 pilha_cheia,
   output logic                 carry,
   output logic                 zero,
   output logic                 erro_underflow,
   output logic                 erro_overflow
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_DUP  = 3'b101;
   localparam logic [2:0] OP_SWAP = 3'b110;
   localparam logic [2:0] OP_DROP = 3'b111;

   localparam logic [LARG_CONT-1:0] CONT_UM    = LARG_CONT'(1);
   localparam logic [LARG_CONT-1:0] CONT_DOIS  = LARG_CONT'(2);
   localparam logic [LARG_CONT-1:0] CONT_CHEIA = LARG_CONT'(PROFUNDIDADE);

   typedef enum logic [1:0] {OCIOSO, CALCULA, ESCREVE} estado_t;
   typedef enum logic [1:0] {ACAO_NADA, ACAO_PUSH, ACAO_POP, ACAO_TROCA} acao_t;

   estado_t              estado_reg, estado_next;
   acao_t                acao;
   logic [LARGURA-1:0]   pilha [PROFUNDIDADE];
   logic [LARGURA-1:0]   op_a_reg, op_b_reg, resultado_reg, valor_escrita;
   logic [2:0]           opcode_reg;
   logic [LARG_CONT-1:0] contagem_reg;
   logic                 carry_reg, zero_reg, erro_underflow_reg, erro_overflow_reg;
   logic                 aceita_push, aceita_exec, precisa_dois;
   logic                 falta_operando, falta_espaco, push_ok, exec_ok;
   logic [LARGURA:0]     soma, diferenca;

   assign pilha_cheia    = (contagem_reg == CONT_CHEIA);
   assign pilha_vazia    = (contagem_reg == '0);
   assign aceita_push    = (estado_reg == OCIOSO) && entrada_numero && !executar;
   assign aceita_exec    = (estado_reg == OCIOSO) && executar && !entrada_numero;
   assign precisa_dois   = (operacao <= OP_XOR) || (operacao == OP_SWAP);
   assign falta_operando = aceita_exec &&
                           (precisa_dois ? (contagem_reg < CONT_DOIS) : (contagem_reg < CONT_UM));
   assign falta_espaco   = pilha_cheia && (aceita_push || (aceita_exec && operacao == OP_DUP));
   assign push_ok        = aceita_push && !pilha_cheia;
   assign exec_ok        = aceita_exec && !falta_operando && !falta_espaco;
   assign soma           = {1'b0, op_b_reg} + {1'b0, op_a_reg};
   assign diferenca      = {1'b0, op_b_reg} - {1'b0, op_a_reg};

   // Each element picks its neighbour above (push), below (pop) or its swap partner.
   // Element 0 always takes valor_escrita, so the new top is known in one place.
   for (genvar gi = 0; gi < PROFUNDIDADE; gi++) begin : g_elem
      logic [LARGURA-1:0] valor_reg, valor_next, de_cima, de_baixo, troca;
      if (gi == 0) begin : g_topo
         assign de_cima  = valor_escrita;
         assign de_baixo = valor_escrita;
         assign troca    = valor_escrita;
      end else begin : g_resto
         assign de_cima = pilha[gi-1];
         assign troca   = (gi == 1) ? op_a_reg : valor_reg;
         if (gi == PROFUNDIDADE - 1) begin : g_fundo
            assign de_baixo = '0;
         end else begin : g_meio
            assign de_baixo = pilha[gi+1];
         end
      end
      always_comb begin
         case (acao)
            ACAO_PUSH:  valor_next = de_cima;
            ACAO_POP:   valor_next = de_baixo;
            ACAO_TROCA: valor_next = troca;
            default:    valor_next = valor_reg;
         endcase
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) valor_reg <= '0;
         else     valor_reg <= valor_next;
      end
      assign pilha[gi] = valor_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado_reg <= OCIOSO;
      else     estado_reg <= estado_next;
   end

   always_comb begin
      estado_next = estado_reg;
      case (estado_reg)
         OCIOSO:  if (exec_ok) estado_next = CALCULA;
         CALCULA: estado_next = ESCREVE;
         ESCREVE: estado_next = OCIOSO;
         default: estado_next = OCIOSO;
      endcase
   end

   always_comb begin
      pronto        = 1'b0;
      acao          = ACAO_NADA;
      valor_escrita = entrada;
      case (estado_reg)
         OCIOSO: begin
            pronto = 1'b1;
            if (push_ok) acao = ACAO_PUSH;
         end
         ESCREVE: begin
            case (opcode_reg)
               OP_DUP:  begin acao = ACAO_PUSH;  valor_escrita = op_a_reg;      end
               OP_SWAP: begin acao = ACAO_TROCA; valor_escrita = op_b_reg;      end
               OP_DROP: begin acao = ACAO_POP;   valor_escrita = pilha[1];      end
               default: begin acao = ACAO_POP;   valor_escrita = resultado_reg; end
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a_reg           <= '0;
         op_b_reg           <= '0;
         opcode_reg         <= OP_ADD;
         resultado_reg      <= '0;
         contagem_reg       <= '0;
         carry_reg          <= 1'b0;
         zero_reg           <= 1'b0;
         erro_underflow_reg <= 1'b0;
         erro_overflow_reg  <= 1'b0;
      end else begin
         if (exec_ok) begin
            op_a_reg   <= pilha[0];
            op_b_reg   <= pilha[1];
            opcode_reg <= operacao;
         end
         if (estado_reg == CALCULA) begin
            case (opcode_reg)
               OP_ADD:  begin resultado_reg <= soma[LARGURA-1:0];      carry_reg <= soma[LARGURA];      end
               OP_SUB:  begin resultado_reg <= diferenca[LARGURA-1:0]; carry_reg <= diferenca[LARGURA]; end
               OP_AND:  resultado_reg <= op_b_reg & op_a_reg;
               OP_OR:   resultado_reg <= op_b_reg | op_a_reg;
               OP_XOR:  resultado_reg <= op_b_reg ^ op_a_reg;
               default: resultado_reg <= resultado_reg;
            endcase
         end
         case (acao)
            ACAO_PUSH: contagem_reg <= contagem_reg + CONT_UM;
            ACAO_POP:  contagem_reg <= contagem_reg - CONT_UM;
            default:   contagem_reg <= contagem_reg;
         endcase
         if (acao != ACAO_NADA) zero_reg <= (valor_escrita == '0);
         // A new error in the same cycle as a clear request keeps the flag set.
         erro_underflow_reg <= falta_operando ? 1'b1 : (limpar_erro ? 1'b0 : erro_underflow_reg);
         erro_overflow_reg  <= falta_espaco   ? 1'b1 : (limpar_erro ? 1'b0 : erro_overflow_reg);
      end
   end

   assign topo           = pilha[0];
   assign segundo        = pilha[1];
   assign contagem       = contagem_reg;
   assign carry          = carry_reg;
   assign zero           = zero_reg;
   assign erro_underflow = erro_underflow_reg;
   assign erro_overflow  = erro_overflow_reg;

endmodule

// File: tb/tb_pilha_rpn_param.sv
// Scoreboard bench for pilha_rpn_param (8-bit, depth 4): the driver queues hand-computed
// expectations, the monitor checks them whenever the stack reports pronto.
module tb_pilha_rpn_param;
    localparam int W = 8;
    localparam int D = 4;
    localparam int C = $clog2(D + 1);

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, DUP = 3'b101, SWAP = 3'b110, DROP = 3'b111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] entrada = '0;
    logic         entrada_numero = 1'b0, executar = 1'b0, limpar_erro = 1'b0;
    logic [2:0]   operacao = 3'b000;
    logic         pronto, pilha_vazia, pilha_cheia, carry, zero, erro_underflow, erro_overflow;
    logic [W-1:0] topo, segundo;
    logic [C-1:0] contagem;

    pilha_rpn_param #(.LARGURA(W), .PROFUNDIDADE(D)) dut (
        .clk(clk), .rst(rst), .entrada(entrada), .entrada_numero(entrada_numero),
        .executar(executar), .operacao(operacao), .limpar_erro(limpar_erro),
        .pronto(pronto), .topo(topo), .segundo(segundo), .contagem(contagem),
        .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia), .carry(carry), .zero(zero),
        .erro_underflow(erro_underflow), .erro_overflow(erro_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nome;
        logic [W-1:0] topo;
        logic [W-1:0] segundo;
        logic [C-1:0] cont;
        logic [3:0]   flags;   // {carry, zero, erro_underflow, erro_overflow}
        int           espera;  // falling edges spent with pronto low before the result
    } esperado_t;

    esperado_t fila[$];
    esperado_t m;
    int checks = 0, errors = 0, emitidos = 0, consumidos = 0, ocupado = 0;

    function automatic esperado_t esp(input string n, input logic [W-1:0] t, input logic [W-1:0] s,
                                      input int c, input logic [3:0] f, input int e);
        esperado_t r;
        r.nome = n; r.topo = t; r.segundo = s; r.cont = C'(c); r.flags = f; r.espera = e;
        return r;
    endfunction

    always @(negedge clk) begin
        if (consumidos < emitidos) begin
            if (!pronto && ocupado < 10) begin
                ocupado++;
            end else begin
                m = fila.pop_front();
                checks++;
                if (pronto === 1'b1 && topo === m.topo && segundo === m.segundo && contagem === m.cont &&
                    pilha_vazia === (m.cont == '0) && pilha_cheia === (m.cont == C'(D)) &&
                    {carry, zero, erro_underflow, erro_overflow} === m.flags && ocupado == m.espera)
                    $display("%-16s topo=%h seg=%h cont=%0d cz_uo=%b busy=%0d", m.nome, topo, segundo,
                             contagem, {carry, zero, erro_underflow, erro_overflow}, ocupado);
                else begin
                    errors++;
                    $display("FAIL %s: got topo=%h seg=%h cont=%0d vazia=%b cheia=%b cz_uo=%b pronto=%b busy=%0d; want topo=%h seg=%h cont=%0d cz_uo=%b busy=%0d",
                             m.nome, topo, segundo, contagem, pilha_vazia, pilha_cheia,
                             {carry, zero, erro_underflow, erro_overflow}, pronto, ocupado,
                             m.topo, m.segundo, m.cont, m.flags, m.espera);
                end
                consumidos++;
                ocupado = 0;
            end
        end
    end

    task automatic espera_borda();
        @(posedge clk);
        #1;
    endtask

    task automatic aguarda();
        for (int k = 0; k < 40; k++) begin
            espera_borda();
            if (consumidos >= emitidos) return;
        end
        $display("FAIL monitor_stall: consumed=%0d issued=%0d", consumidos, emitidos);
        $fatal(1, "monitor stalled");
    endtask

    task automatic comando(input logic num, input logic exe, input logic limpa, input logic [W-1:0] val,
                           input logic [2:0] op, input logic intruso, input esperado_t e);
        entrada = val; entrada_numero = num; executar = exe; operacao = op; limpar_erro = limpa;
        espera_borda();
        entrada_numero = 1'b0; executar = 1'b0; limpar_erro = 1'b0;
        fila.push_back(e);
        emitidos++;
        if (intruso) begin
            entrada = 8'h55; entrada_numero = 1'b1;
            espera_borda();
            entrada_numero = 1'b0;
        end
        aguarda();
    endtask

    task automatic push(input logic [W-1:0] v, input esperado_t e);
        comando(1'b1, 1'b0, 1'b0, v, ADD, 1'b0, e);
    endtask

    task automatic exec(input logic [2:0] op, input esperado_t e);
        comando(1'b0, 1'b1, 1'b0, 8'h00, op, 1'b0, e);
    endtask

    task automatic limpa(input esperado_t e);
        comando(1'b0, 1'b0, 1'b1, 8'h00, ADD, 1'b0, e);
    endtask

    initial begin
        fila.push_back(esp("reset", 8'h00, 8'h00, 0, 4'b0000, 0));
        emitidos = 1;
        aguarda();
        rst = 1'b0;

        push(8'h05, esp("push_05",   8'h05, 8'h00, 1, 4'b0000, 0));
        push(8'h03, esp("push_03",   8'h03, 8'h05, 2, 4'b0000, 0));
        exec(ADD,   esp("add_5_3",   8'h08, 8'h00, 1, 4'b0000, 2));
        exec(DROP,  esp("drop_last", 8'h00, 8'h00, 0, 4'b0100, 2));
        push(8'h10, esp("push_10",   8'h10, 8'h00, 1, 4'b0000, 0));
        push(8'h20, esp("push_20",   8'h20, 8'h10, 2, 4'b0000, 0));
        exec(SUB,   esp("sub_borrow",8'hF0, 8'h00, 1, 4'b1000, 2));
        push(8'hFF, esp("push_ff",   8'hFF, 8'hF0, 2, 4'b1000, 0));
        push(8'h01, esp("push_01",   8'h01, 8'hFF, 3, 4'b1000, 0));
        exec(ADD,   esp("add_wrap",  8'h00, 8'hF0, 2, 4'b1100, 2));
        exec(XOR_,  esp("xor",       8'hF0, 8'h00, 1, 4'b1000, 2));
        exec(DROP,  esp("drop_f0",   8'h00, 8'h00, 0, 4'b1100, 2));

        push(8'h01, esp("fill_1",    8'h01, 8'h00, 1, 4'b1000, 0));
        push(8'h02, esp("fill_2",    8'h02, 8'h01, 2, 4'b1000, 0));
        push(8'h03, esp("fill_3",    8'h03, 8'h02, 3, 4'b1000, 0));
        push(8'h04, esp("fill_4",    8'h04, 8'h03, 4, 4'b1000, 0));
        push(8'h05, esp("push_full", 8'h04, 8'h03, 4, 4'b1001, 0));
        exec(DUP,   esp("dup_full",  8'h04, 8'h03, 4, 4'b1001, 0));
        limpa(      esp("clear_ovf", 8'h04, 8'h03, 4, 4'b1000, 0));
        exec(AND_,  esp("and_3_4",   8'h00, 8'h02, 3, 4'b1100, 2));
        exec(OR_,   esp("or_2_0",    8'h02, 8'h01, 2, 4'b1000, 2));
        exec(DROP,  esp("drop_a",    8'h01, 8'h00, 1, 4'b1000, 2));
        exec(DROP,  esp("drop_b",    8'h00, 8'h00, 0, 4'b1100, 2));

        exec(ADD,   esp("add_empty", 8'h00, 8'h00, 0, 4'b1110, 0));
        push(8'h07, esp("push_07",   8'h07, 8'h00, 1, 4'b1010, 0));
        limpa(      esp("clear_unf", 8'h07, 8'h00, 1, 4'b1000, 0));
        comando(1'b0, 1'b1, 1'b1, 8'h00, SWAP, 1'b0,
                    esp("swap1_clr", 8'h07, 8'h00, 1, 4'b1010, 0));
        limpa(      esp("clear_unf2",8'h07, 8'h00, 1, 4'b1000, 0));
        exec(DROP,  esp("drop_07",   8'h00, 8'h00, 0, 4'b1100, 2));

        push(8'h01, esp("push_1",    8'h01, 8'h00, 1, 4'b1000, 0));
        push(8'h02, esp("push_2",    8'h02, 8'h01, 2, 4'b1000, 0));
        exec(SWAP,  esp("swap",      8'h01, 8'h02, 2, 4'b1000, 2));
        exec(DUP,   esp("dup",       8'h01, 8'h01, 3, 4'b1000, 2));
        comando(1'b0, 1'b1, 1'b0, 8'h00, DROP, 1'b1,
                    esp("drop_intr", 8'h01, 8'h02, 2, 4'b1000, 2));
        comando(1'b1, 1'b1, 1'b0, 8'h09, ADD, 1'b0,
                    esp("both_strb", 8'h01, 8'h02, 2, 4'b1000, 0));

        entrada_numero = 1'b0; executar = 1'b1; operacao = ADD;
        espera_borda();
        executar = 1'b0;
        rst = 1'b1;
        fila.push_back(esp("rst_calcula", 8'h00, 8'h00, 0, 4'b0000, 0));
        emitidos++;
        aguarda();
        rst = 1'b0;
        push(8'h09, esp("push_post", 8'h09, 8'h00, 1, 4'b0000, 0));

        if (checks != emitidos) begin
            errors++;
            $display("FAIL check_count: checks=%0d issued=%0d", checks, emitidos);
        end else
            $display("check_count      checks=%0d issued=%0d", checks, emitidos);
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left", fila.size());
        end else
            $display("queue_drain      empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
